// File: rtl/exc_mem_sequencer.sv
// Exception sequencer: borrows the memory-address mux select from the main
// control, saves EPC, reads a handler-vector byte (253/254/255) into MDR and
// loads PC from it, holding busy high so the main control stalls meanwhile.
module exc_mem_sequencer #(
  parameter int MEM_WAIT = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] ctrl_mem_sel,
  input  logic       op_invalid,
  input  logic       overflow,
  input  logic       div_zero,
  output logic [2:0] MemoryAdress,
  output logic       epc_write,
  output logic       mdr_write,
  output logic       pc_write,
  output logic       pc_src_exc,
  output logic       busy,
  output logic       done,
  output logic [1:0] exc_cause
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SAVE_EPC,
    S_ADDR,
    S_LOAD,
    S_JUMP
  } state_t;

  // Last counter value spent in ADDR before moving to LOAD.
  localparam logic [2:0] CNT_LAST = 3'(MEM_WAIT - 1);

  state_t     r_state;
  logic [2:0] r_cnt;
  logic [1:0] r_cause;
  logic [2:0] r_vec_sel;
  logic       r_own_mux;
  logic       r_epc_write;
  logic       r_mdr_write;
  logic       r_pc_write;
  logic       r_busy;
  logic       r_done;

  logic       w_any_flag;
  logic [1:0] w_new_cause;
  logic [2:0] w_new_vec;

  // Cause encoding with fixed priority: opcode > overflow > div0.
  function automatic logic [1:0] pick_cause(input logic opi, input logic ovf);
    if (opi)      return 2'b01;
    else if (ovf) return 2'b10;
    else          return 2'b11;
  endfunction

  // Mux select that addresses the handler-vector byte for a given cause.
  function automatic logic [2:0] vec_sel(input logic [1:0] cause);
    case (cause)
      2'b01:   return 3'b100;
      2'b10:   return 3'b101;
      default: return 3'b110;
    endcase
  endfunction

  assign w_any_flag  = op_invalid | overflow | div_zero;
  assign w_new_cause = pick_cause(op_invalid, overflow);
  assign w_new_vec   = vec_sel(w_new_cause);

  // Sequencer FSM; strobes are registered alongside the state they belong to.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= 3'd0;
      r_cause     <= 2'b00;
      r_vec_sel   <= 3'b000;
      r_own_mux   <= 1'b0;
      r_epc_write <= 1'b0;
      r_mdr_write <= 1'b0;
      r_pc_write  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_own_mux   <= 1'b0;
      r_epc_write <= 1'b0;
      r_mdr_write <= 1'b0;
      r_pc_write  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // Flags are only looked at here; anything raised while busy is lost.
          if (w_any_flag) begin
            r_state     <= S_SAVE_EPC;
            r_cause     <= w_new_cause;
            r_vec_sel   <= w_new_vec;
            r_epc_write <= 1'b1;
            r_busy      <= 1'b1;
          end
        end
        S_SAVE_EPC: begin
          r_state   <= S_ADDR;
          r_cnt     <= 3'd0;
          r_own_mux <= 1'b1;
          r_busy    <= 1'b1;
        end
        S_ADDR: begin
          r_cnt     <= r_cnt + 3'd1;
          r_own_mux <= 1'b1;
          r_busy    <= 1'b1;
          if (r_cnt == CNT_LAST) begin
            r_state     <= S_LOAD;
            r_mdr_write <= 1'b1;
          end
        end
        S_LOAD: begin
          r_state    <= S_JUMP;
          r_pc_write <= 1'b1;
          r_done     <= 1'b1;
          r_busy     <= 1'b1;
        end
        S_JUMP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // The vector select is only driven in ADDR and LOAD; otherwise main control owns the mux.
  assign MemoryAdress = r_own_mux ? r_vec_sel : ctrl_mem_sel;
  assign epc_write    = r_epc_write;
  assign mdr_write    = r_mdr_write;
  assign pc_write     = r_pc_write;
  assign pc_src_exc   = r_pc_write;
  assign busy         = r_busy;
  assign done         = r_done;
  assign exc_cause    = r_cause;

endmodule

// File: tb/tb_exc_mem_sequencer.sv
// Testbench for exc_mem_sequencer: three instances (MEM_WAIT 1, 2, 7) share
// one stimulus stream; a position-in-sequence model predicts each one's
// outputs, expectations are queued and a negedge monitor checks them.
module tb_exc_mem_sequencer;

  logic       clk;
  logic       reset;
  logic [2:0] ctrl_mem_sel;
  logic       op_invalid;
  logic       overflow;
  logic       div_zero;

  logic [2:0] ma0, ma1, ma2;
  logic       epc0, epc1, epc2, mdr0, mdr1, mdr2, pcw0, pcw1, pcw2;
  logic       src0, src1, src2, bsy0, bsy1, bsy2, dn0, dn1, dn2;
  logic [1:0] cau0, cau1, cau2;

  exc_mem_sequencer #(.MEM_WAIT(1)) u_mw1 (
    .clk(clk), .reset(reset), .ctrl_mem_sel(ctrl_mem_sel),
    .op_invalid(op_invalid), .overflow(overflow), .div_zero(div_zero),
    .MemoryAdress(ma0), .epc_write(epc0), .mdr_write(mdr0), .pc_write(pcw0),
    .pc_src_exc(src0), .busy(bsy0), .done(dn0), .exc_cause(cau0));

  exc_mem_sequencer #(.MEM_WAIT(2)) u_mw2 (
    .clk(clk), .reset(reset), .ctrl_mem_sel(ctrl_mem_sel),
    .op_invalid(op_invalid), .overflow(overflow), .div_zero(div_zero),
    .MemoryAdress(ma1), .epc_write(epc1), .mdr_write(mdr1), .pc_write(pcw1),
    .pc_src_exc(src1), .busy(bsy1), .done(dn1), .exc_cause(cau1));

  exc_mem_sequencer #(.MEM_WAIT(7)) u_mw7 (
    .clk(clk), .reset(reset), .ctrl_mem_sel(ctrl_mem_sel),
    .op_invalid(op_invalid), .overflow(overflow), .div_zero(div_zero),
    .MemoryAdress(ma2), .epc_write(epc2), .mdr_write(mdr2), .pc_write(pcw2),
    .pc_src_exc(src2), .busy(bsy2), .done(dn2), .exc_cause(cau2));

  // Packed view: {MemoryAdress, epc, mdr, pc, pc_src, busy, done, cause}
  logic [10:0] act [3];
  assign act[0] = {ma0, epc0, mdr0, pcw0, src0, bsy0, dn0, cau0};
  assign act[1] = {ma1, epc1, mdr1, pcw1, src1, bsy1, dn1, cau1};
  assign act[2] = {ma2, epc2, mdr2, pcw2, src2, bsy2, dn2, cau2};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [10:0] q0[$];
  logic [10:0] q1[$];
  logic [10:0] q2[$];

  // Model: pos 0 = idle, 1..L = cycle index within a sequence of L = MEM_WAIT+3.
  int         mw    [3] = '{1, 2, 7};
  int         m_pos [3];
  logic [1:0] m_cause [3];

  task automatic model_step(input logic rst, input logic opi, input logic ovf, input logic dz);
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        m_pos[i]   = 0;
        m_cause[i] = 2'b00;
      end else if (m_pos[i] == 0) begin
        if (opi || ovf || dz) begin
          m_pos[i]   = 1;
          m_cause[i] = opi ? 2'b01 : (ovf ? 2'b10 : 2'b11);
        end
      end else begin
        m_pos[i] = (m_pos[i] == mw[i] + 3) ? 0 : m_pos[i] + 1;
      end
    end
  endtask

  function automatic logic [10:0] model_out(input int i, input logic [2:0] sel);
    int         len;
    int         p;
    logic [2:0] ma;
    logic       in_vec;
    len    = mw[i] + 3;
    p      = m_pos[i];
    in_vec = (p >= 2) && (p <= len - 1);
    if (in_vec)
      ma = (m_cause[i] == 2'b01) ? 3'b100 : ((m_cause[i] == 2'b10) ? 3'b101 : 3'b110);
    else
      ma = sel;
    return {ma, (p == 1), (p == len - 1), (p == len), (p == len), (p != 0), (p == len), m_cause[i]};
  endfunction

  // One clock: apply the edge to the model, drive next inputs, queue expectations.
  task automatic cycle(input logic rst, input logic [2:0] sel,
                       input logic opi, input logic ovf, input logic dz);
    @(posedge clk);
    model_step(reset, op_invalid, overflow, div_zero);
    #1;
    reset        = rst;
    ctrl_mem_sel = sel;
    op_invalid   = opi;
    overflow     = ovf;
    div_zero     = dz;
    q0.push_back(model_out(0, sel));
    q1.push_back(model_out(1, sel));
    q2.push_back(model_out(2, sel));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, 3'($urandom_range(0, 7)), 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_one(input string name, input logic [10:0] a, input logic [10:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s at %0t: got ma=%b epc/mdr/pc/src/busy/done=%b cause=%b, want ma=%b epc/mdr/pc/src/busy/done=%b cause=%b",
               name, $time, a[10:8], a[7:2], a[1:0], e[10:8], e[7:2], e[1:0]);
    end
  endtask

  // Monitor: every negedge compare whatever expectations are pending.
  initial begin
    forever begin
      @(negedge clk);
      if (q0.size() > 0) check_one("mw1", act[0], q0.pop_front());
      if (q1.size() > 0) check_one("mw2", act[1], q1.pop_front());
      if (q2.size() > 0) check_one("mw7", act[2], q2.pop_front());
    end
  end

  initial begin
    reset        = 1'b1;
    ctrl_mem_sel = 3'b000;
    op_invalid   = 1'b0;
    overflow     = 1'b0;
    div_zero     = 1'b0;
    for (int i = 0; i < 3; i++) begin
      m_pos[i]   = 0;
      m_cause[i] = 2'b00;
    end
    @(posedge clk);
    // Reset state with differing selects
    cycle(1'b1, 3'b011, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 3'b101, 1'b0, 1'b0, 1'b0);
    // Passthrough sweep
    for (int s = 0; s < 8; s++) cycle(1'b0, 3'(s), 1'b0, 1'b0, 1'b0);
    // Single-cycle overflow pulse
    cycle(1'b0, 3'b010, 1'b0, 1'b1, 1'b0);
    idle(12);
    // All flags together: opcode wins, one sequence only
    cycle(1'b0, 3'b001, 1'b1, 1'b1, 1'b1);
    idle(12);
    // div_zero raised during ADDR of an opcode sequence, dropped before JUMP
    cycle(1'b0, 3'b000, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 3'b111, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 3'b111, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 3'b111, 1'b0, 1'b0, 1'b1);
    idle(12);
    // Reset during LOAD of the MEM_WAIT=2 instance
    cycle(1'b0, 3'b011, 1'b0, 1'b1, 1'b0);
    idle(3);
    cycle(1'b1, 3'b110, 1'b0, 1'b0, 1'b0);
    idle(12);
    // div_zero vector hold lengths
    cycle(1'b0, 3'b000, 1'b0, 1'b0, 1'b1);
    idle(12);
    // Flag held continuously: restarts right after each JUMP
    for (int k = 0; k < 14; k++) cycle(1'b0, 3'($urandom_range(0, 7)), 1'b0, 1'b1, 1'b0);
    idle(12);
    // Random traffic
    for (int k = 0; k < 600; k++) begin
      cycle(($urandom_range(0, 63) == 0), 3'($urandom_range(0, 7)),
            ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 9) == 0));
    end
    idle(2);
    @(negedge clk);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/exc_mem_sequencer.md
Name: exc_mem_sequencer

Overview:
- Multicycle exception sequencer that owns the 3-bit memory-address mux select (MemoryAdress) on behalf of the main control unit.
- In IDLE it passes the main control's select through unchanged.
- On invalid-opcode, ALU overflow or divide-by-zero, it takes the mux and runs a fixed sequence: save EPC, address handler-vector byte 253/254/255, capture the byte into MDR, load PC.
- It holds `busy` high for the whole sequence so the main control stalls.

Parameters:
- MEM_WAIT, 2, cycles the vector address is held before MDR capture (memory read latency); legal range 1..7.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- ctrl_mem_sel  input  3  MemoryAdress select requested by main control
- op_invalid  input  1  invalid-opcode flag, level
- overflow  input  1  ALU overflow flag, level
- div_zero  input  1  divide-by-zero flag, level
- MemoryAdress  output  3  select driven to the memory-address mux
- epc_write  output  1  EPC register load strobe
- mdr_write  output  1  MDR load strobe (exception byte)
- pc_write  output  1  PC load strobe
- pc_src_exc  output  1  PC source = zero-extended MDR byte
- busy  output  1  sequencer owns datapath; main control must stall
- done  output  1  one-cycle pulse in the final sequence cycle
- exc_cause  output  2  last cause: 00 none, 01 opcode, 10 overflow, 11 div0

Behaviour:
- Reset is synchronous, active-high, and beats all other inputs in its cycle.
- Reset result: state=IDLE, wait counter=0, exc_cause=00. All strobes, busy and done are 0. MemoryAdress = ctrl_mem_sel.
- Reset mid-sequence aborts at the next edge. No further strobes are issued and no partial PC load occurs.
- Outputs are Moore-decoded from registered state (plus the IDLE passthrough). exc_cause is a register.
- States: IDLE, SAVE_EPC, ADDR, LOAD, JUMP.
- IDLE:
  - MemoryAdress = ctrl_mem_sel (combinational passthrough); busy=0.
  - Flags are sampled only in IDLE.
  - If any flag is high at an edge: latch cause with priority op_invalid > overflow > div_zero, then go to SAVE_EPC.
  - Simultaneous flags: only the highest-priority flag is served; the others are dropped.
- SAVE_EPC:
  - epc_write=1, busy=1.
  - MemoryAdress = ctrl_mem_sel (memory unused this cycle).
  - Next state is ADDR; counter cleared to 0.
- ADDR:
  - busy=1. MemoryAdress = 100 (addr 253) for opcode, 101 (254) for overflow, 110 (255) for div0.
  - Counter increments each cycle. After MEM_WAIT cycles in ADDR, go to LOAD.
- LOAD:
  - MemoryAdress held at the vector select; mdr_write=1, busy=1.
  - Next state is JUMP.
- JUMP:
  - pc_write=1, pc_src_exc=1, done=1, busy=1.
  - MemoryAdress = ctrl_mem_sel.
  - Next state is IDLE.
- Sequence length:
  - Flag seen at edge N → busy high for cycles N+1 .. N+3+MEM_WAIT.
  - With MEM_WAIT=2: 5 busy cycles, the last of which is JUMP.
- Flags asserted while busy are ignored, never queued.
- A flag still high in the first IDLE cycle after JUMP starts a new sequence.
  - This is a known hazard: the main control must have deasserted it.
- exc_cause holds its value after JUMP until the next exception or reset.
- Strobes are mutually exclusive: at most one of epc_write, mdr_write, pc_write is high in any cycle.
- Counter is 3 bits and never wraps for legal MEM_WAIT.

Test Plan:
- Reset, then ctrl_mem_sel sweeps 000..111 with no flags → MemoryAdress tracks each value in the same cycle; busy=0; all strobes 0.
- overflow pulsed 1 cycle, MEM_WAIT=2:
  - epc_write in cycle 1; MemoryAdress=101 in cycles 2-4; mdr_write in cycle 4.
  - pc_write+pc_src_exc+done in cycle 5; busy in cycles 1-5; exc_cause=10.
- op_invalid, overflow and div_zero all high together → MemoryAdress=100, exc_cause=01, exactly one sequence.
- div_zero raised during ADDR of an opcode sequence, dropped before JUMP → ignored; exc_cause stays 01; returns to IDLE.
- reset asserted in the LOAD cycle → next cycle state IDLE, pc_write never asserts, exc_cause=00, MemoryAdress=ctrl_mem_sel.
- MEM_WAIT=1 and MEM_WAIT=7 with div_zero → MemoryAdress=110 held exactly 2 and 8 cycles respectively; done exactly 4 and 10 cycles after the flag edge.
